// File: rtl/reaction_stats.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_stats
//  Description : Reaction-time statistics engine. Measures milliseconds from
//                each ball spawn to its hit and keeps last, best and
//                floor-average reaction times plus a saturating hit count.
//                The average comes from a 17-cycle restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_stats #(
    parameter int MS_DIV   = 100000,
    parameter int MAX_MS   = 999,
    parameter int MAX_HITS = 127
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       start,
    input  logic       new_ball,
    output logic [9:0] last_ms,
    output logic [9:0] best_ms,
    output logic [9:0] avg_ms,
    output logic [6:0] hit_count,
    output logic       stats_valid,
    output logic       busy,
    output logic       avg_done
);

    localparam int                 c_PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int                 c_SUM_W    = 17;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(MS_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [9:0]         c_MAX_MS   = 10'(MAX_MS);
    localparam logic [6:0]         c_MAX_HITS = 7'(MAX_HITS);
    localparam logic [4:0]         c_DIV_LAST = 5'(c_SUM_W - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_start_q;
    logic               r_ball_q;
    logic [c_PRE_W-1:0] r_presc;
    logic [9:0]         r_ms_cnt;
    logic [c_SUM_W-1:0] r_sum;
    logic               r_pend;
    logic [9:0]         r_last;
    logic [9:0]         r_best;
    logic [9:0]         r_avg;
    logic [6:0]         r_hits;
    logic               r_avg_done;
    logic [4:0]         r_div_cnt;
    logic [6:0]         r_rem;
    logic [c_SUM_W-1:0] r_quo;

    logic               w_start_rise;
    logic               w_hit;
    logic               w_ms_tick;
    logic               w_take;
    logic               w_record;
    logic               w_div_last;
    logic [c_SUM_W-1:0] w_sum_nxt;
    logic [7:0]         w_trial;
    logic               w_ge;
    logic [6:0]         w_diff;
    logic [6:0]         w_rem_nxt;
    logic [c_SUM_W-1:0] w_quo_nxt;

    assign w_start_rise = start & ~r_start_q;
    assign w_hit        = new_ball & ~r_ball_q;
    assign w_ms_tick    = (r_state != c_IDLE) && (r_presc == c_PRE_LAST);

    // A hit is taken in RUN either fresh or replayed from the pending flag;
    // a falling start wins over any hit in the same cycle.
    assign w_take     = (r_state == c_RUN) && start && (w_hit || r_pend);
    assign w_record   = w_take && (r_hits < c_MAX_HITS);
    assign w_div_last = (r_state == c_DIV) && (r_div_cnt == c_DIV_LAST);
    assign w_sum_nxt  = r_sum + c_SUM_W'(r_ms_cnt);

    // Restoring divider step: the remainder stays below the divisor (<=127),
    // so the trial value fits 8 bits and a 7-bit difference is exact.
    assign w_trial   = {r_rem, r_quo[c_SUM_W-1]};
    assign w_ge      = (w_trial >= {1'b0, r_hits});
    assign w_diff    = w_trial[6:0] - r_hits;
    assign w_rem_nxt = w_ge ? w_diff : w_trial[6:0];
    assign w_quo_nxt = {r_quo[c_SUM_W-2:0], w_ge};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_rise) w_state_nxt = c_RUN;
            c_RUN: begin
                if (!start)        w_state_nxt = c_IDLE;
                else if (w_record) w_state_nxt = c_DIV;
            end
            c_DIV:   if (w_div_last) w_state_nxt = start ? c_RUN : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Edge registers, ms timebase, statistics and divider datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q  <= 1'b0;
            r_ball_q   <= 1'b0;
            r_presc    <= '0;
            r_ms_cnt   <= '0;
            r_sum      <= '0;
            r_pend     <= 1'b0;
            r_last     <= '0;
            r_best     <= '0;
            r_avg      <= '0;
            r_hits     <= '0;
            r_avg_done <= 1'b0;
            r_div_cnt  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
        end else begin
            r_start_q  <= start;
            r_ball_q   <= new_ball;
            r_avg_done <= 1'b0;

            // Timebase: only runs inside a round; any taken hit restarts it.
            if (r_state == c_IDLE) begin
                if (w_start_rise) begin
                    r_presc  <= '0;
                    r_ms_cnt <= '0;
                end
            end else if (w_take) begin
                r_presc  <= '0;
                r_ms_cnt <= '0;
            end else if (w_ms_tick) begin
                r_presc <= '0;
                if (r_ms_cnt < c_MAX_MS) r_ms_cnt <= r_ms_cnt + 10'd1;
            end else begin
                r_presc <= r_presc + c_PRE_ONE;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_start_rise) begin
                        r_last <= '0;
                        r_best <= '0;
                        r_avg  <= '0;
                        r_hits <= '0;
                        r_sum  <= '0;
                        r_pend <= 1'b0;
                    end
                end
                c_RUN: begin
                    // Pending is either consumed here or dropped as start falls.
                    r_pend <= 1'b0;
                    if (w_record) begin
                        r_last <= r_ms_cnt;
                        if ((r_hits == 7'd0) || (r_ms_cnt < r_best)) r_best <= r_ms_cnt;
                        r_sum     <= w_sum_nxt;
                        r_hits    <= r_hits + 7'd1;
                        r_quo     <= w_sum_nxt;
                        r_rem     <= '0;
                        r_div_cnt <= '0;
                    end
                end
                c_DIV: begin
                    r_quo     <= w_quo_nxt;
                    r_rem     <= w_rem_nxt;
                    r_div_cnt <= r_div_cnt + 5'd1;
                    if (w_hit) r_pend <= 1'b1;
                    if (w_div_last) begin
                        // Quotient never exceeds the ms ceiling, so 10 bits hold it.
                        r_avg      <= w_quo_nxt[9:0];
                        r_avg_done <= 1'b1;
                        if (!start) r_pend <= 1'b0;
                    end
                end
                default: r_pend <= 1'b0;
            endcase
        end
    end

    assign last_ms     = r_last;
    assign best_ms     = r_best;
    assign avg_ms      = r_avg;
    assign hit_count   = r_hits;
    assign stats_valid = (r_hits != 7'd0);
    assign busy        = (r_state == c_DIV);
    assign avg_done    = r_avg_done;

endmodule
`default_nettype wire

// File: tb/tb_reaction_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_stats
//  Description : Scoreboard bench for reaction_stats (MS_DIV = 4). Stimulus
//                pushes expected stats; a monitor pops on every avg_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_stats;

    localparam int MS_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       new_ball;
    logic [9:0] last_ms;
    logic [9:0] best_ms;
    logic [9:0] avg_ms;
    logic [6:0] hit_count;
    logic       stats_valid;
    logic       busy;
    logic       avg_done;

    typedef struct {
        int last;
        int best;
        int avg;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   chg_cyc  = 0;
    int   prev_cnt = 0;

    always #5 clk = ~clk;

    // Edge counter: at any negedge, cyc is the number of the last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    reaction_stats #(
        .MS_DIV  (MS_DIV),
        .MAX_MS  (999),
        .MAX_HITS(127)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .new_ball   (new_ball),
        .last_ms    (last_ms),
        .best_ms    (best_ms),
        .avg_ms     (avg_ms),
        .hit_count  (hit_count),
        .stats_valid(stats_valid),
        .busy       (busy),
        .avg_done   (avg_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int l, input int b, input int a, input int c);
        exp_t e;
        e.last = l; e.best = b; e.avg = a; e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raise new_ball so its rising edge is detected at posedge t.
    task automatic hit_at(input int t, input int hold);
        wait_cyc(t - 1);
        new_ball = 1'b1;
        repeat (hold) @(negedge clk);
        new_ball = 1'b0;
    endtask

    task automatic start_round(output int e0);
        @(negedge clk);
        start = 1'b1;
        e0    = cyc + 1;
    endtask

    // Monitor: every avg_done must match the oldest expected entry and arrive
    // 17 cycles after the hit count last changed.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (int'(hit_count) != prev_cnt) begin
            prev_cnt = int'(hit_count);
            chg_cyc  = cyc;
        end
        if (avg_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_avg_done: got avg_ms=%0d hit_count=%0d expected no pulse", avg_ms, hit_count);
            end else begin
                e = sb_q.pop_front();
                chk("sb_last_ms", int'(last_ms), e.last);
                chk("sb_best_ms", int'(best_ms), e.best);
                chk("sb_avg_ms", int'(avg_ms), e.avg);
                chk("sb_hit_count", int'(hit_count), e.cnt);
                chk("sb_avg_latency", cyc - chg_cyc, 17);
                chk("sb_busy_low", int'(busy), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int h;
        rst      = 1'b0;
        start    = 1'b0;
        new_ball = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_last_ms", int'(last_ms), 0);
        chk("rst_best_ms", int'(best_ms), 0);
        chk("rst_avg_ms", int'(avg_ms), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_stats_valid", int'(stats_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_avg_done", int'(avg_done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Round A: hits at 10, 4, 7, 5, 6 ms. A hit detected m edges after
        // the timebase restart sees floor((m-1)/4) ms.
        start_round(e0);
        push(10, 10, 10, 1);
        hit_at(e0 + 42, 3);
        h = e0 + 42;
        chk("first_hit_count", int'(hit_count), 1);
        chk("first_last_ms", int'(last_ms), 10);
        chk("first_busy", int'(busy), 1);
        push(4, 4, 7, 2);   hit_at(h + 18, 3); h = h + 18;
        push(7, 4, 7, 3);   hit_at(h + 30, 3); h = h + 30;
        push(5, 4, 6, 4);   hit_at(h + 22, 3); h = h + 22;
        push(6, 4, 6, 5);   hit_at(h + 26, 3); h = h + 26;
        wait_cyc(h + 25);
        chk("a_stats_valid", int'(stats_valid), 1);

        // End of round: stats hold, a hit while idle is ignored.
        start = 1'b0;
        repeat (3) @(negedge clk);
        new_ball = 1'b1;
        repeat (3) @(negedge clk);
        new_ball = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_hit_count", int'(hit_count), 5);
        chk("idle_busy", int'(busy), 0);

        // Round B: new round clears stats; a long wait saturates at 999.
        start_round(e0);
        @(negedge clk);
        chk("b_clear_hit_count", int'(hit_count), 0);
        chk("b_clear_last_ms", int'(last_ms), 0);
        chk("b_clear_avg_ms", int'(avg_ms), 0);
        push(999, 999, 999, 1);
        hit_at(e0 + 4100, 3);
        wait_cyc(e0 + 4125);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Round C: new_ball already high at start gives no hit.
        new_ball = 1'b1;
        repeat (2) @(negedge clk);
        start_round(e0);
        wait_cyc(e0 + 20);
        chk("held_hit_count", int'(hit_count), 0);
        chk("held_stats_valid", int'(stats_valid), 0);
        new_ball = 1'b0;
        push(10, 10, 10, 1);
        hit_at(e0 + 42, 3);
        h = e0 + 42;
        // Rises 5 and 10 cycles into DIV: the first is replayed at h+18 after
        // four prescaler wraps (h+4, h+8, h+12, h+16) -> 4 ms; second dropped.
        push(4, 4, 7, 2);
        hit_at(h + 5, 2);
        hit_at(h + 10, 2);
        wait_cyc(h + 40);
        chk("pend_hit_count", int'(hit_count), 2);
        chk("pend_last_ms", int'(last_ms), 4);
        h = h + 18;

        // Reset in the middle of a division.
        hit_at(h + 42, 3);
        wait_cyc(h + 47);
        chk("middiv_busy", int'(busy), 1);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("mrst_last_ms", int'(last_ms), 0);
        chk("mrst_best_ms", int'(best_ms), 0);
        chk("mrst_avg_ms", int'(avg_ms), 0);
        chk("mrst_hit_count", int'(hit_count), 0);
        chk("mrst_stats_valid", int'(stats_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Round D: first hit 5 ms, then 4 ms each up to saturation at 127.
        start_round(e0);
        push(5, 5, 5, 1);
        hit_at(e0 + 22, 3);
        h = e0 + 22;
        for (int k = 2; k <= 127; k++) begin
            push(4, 4, (5 + 4 * (k - 1)) / k, k);
            hit_at(h + 18, 3);
            h = h + 18;
        end
        // 128th hit at 10 ms must change nothing.
        hit_at(h + 42, 3);
        wait_cyc(h + 70);
        chk("sat_hit_count", int'(hit_count), 127);
        chk("sat_last_ms", int'(last_ms), 4);
        chk("sat_best_ms", int'(best_ms), 4);
        chk("sat_avg_ms", int'(avg_ms), 4);
        chk("sat_busy", int'(busy), 0);

        chk("sb_queue_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
